// File: rtl/led_pwm_fader.sv
// Per-channel PWM LED driver with a linear soft fade toward req ? max_level : 0.
// Optional macro LED_PWM_ACTIVE_LOW_EN inverts the pin drive and makes the reset value all ones.
module led_pwm_fader #(
    parameter int          NCH      = 3,
    parameter int          PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 105469
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [NCH-1:0]      led,
    output logic [NCH-1:0]      fading
);

    localparam logic [31:0] STEP_LAST = 32'(STEP_DIV - 1);

`ifdef LED_PWM_ACTIVE_LOW_EN
    localparam logic [NCH-1:0] LED_OFF = '1;
    localparam logic           LED_INV = 1'b1;
`else
    localparam logic [NCH-1:0] LED_OFF = '0;
    localparam logic           LED_INV = 1'b0;
`endif

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [31:0]         step_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] level  [NCH];
    logic [PWM_BITS-1:0] target [NCH];
    logic [NCH-1:0]      led_next;

    assign step_tick = (step_cnt == STEP_LAST);

    // Shared PWM phase and fade-rate prescaler; all channels stay phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (step_tick) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            target[i]   = req[i] ? max_level : '0;
            fading[i]   = (level[i] != target[i]);
            led_next[i] = (level[i] > pwm_cnt) ^ LED_INV;
        end
    end

    // One unit per step_tick toward the live target, so a reversal continues from the current level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                level[i] <= '0;
            end
        end else if (step_tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (level[i] < target[i]) begin
                    level[i] <= level[i] + PWM_BITS'(1);
                end else if (level[i] > target[i]) begin
                    level[i] <= level[i] - PWM_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= LED_OFF;
        end else begin
            led <= led_next;
        end
    end

endmodule
